// File: rtl/usquare_u_is_b_pkg.sv
// Shared types, constants and helpers for the unary square / bipolar conversion kernels.
// Latency: none (declarations and a pure function only).
// Backpressure: none.
package unary_pkg;

   // Accumulator-plus-inputs sum width for the 1-bit unipolar-to-bipolar converter (range 1..3)
   typedef logic [1:0] acc_t;

   // Constant added every cycle so that P(out=1) = (1 + x) / 2
   localparam acc_t BIPOLAR_BIAS = 2'd1;

   // Out-of-range random indices fold onto the last used shuffle entry
   function automatic int unsigned clamp_idx(input int unsigned rnd, input int unsigned dep);
      return (rnd >= dep) ? (dep - 1) : rnd;
   endfunction

endpackage

// File: rtl/usquare_u_is_b_uni2bi.sv
// Unipolar-to-bipolar stream re-encoder with a 1-bit accumulator (counterpart of Bi2Uni).
// Latency: 1 cycle, input bit of cycle n shows up on out at cycle n+1.
// Backpressure: none, consumes and produces one bit every cycle.
module usquare_u_is_b_uni2bi
   import unary_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic in,
   output logic out
);

   logic acc_q, acc_d;
   logic out_q, out_d;
   acc_t sum;

   // Add input plus bias to the accumulator; a carry past 2 emits a one and keeps the remainder
   always_comb begin
      sum   = {1'b0, acc_q} + {1'b0, in} + BIPOLAR_BIAS;
      out_d = 1'b0;
      acc_d = acc_q;
      if (sum >= 2'd2) begin
         out_d = 1'b1;
         // sum - 2 for sum in 2..3 is just the low bit
         acc_d = sum[0];
      end else begin
         out_d = 1'b0;
         // sum can only be 1 here, which fits the 1-bit accumulator
         acc_d = sum[0];
      end
   end

   // Accumulator starts at 1 so an all-zero input yields 1,0,1,0... from the first cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= 1'b1;
         out_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         out_q <= out_d;
      end
   end

   assign out = out_q;

endmodule

// File: rtl/usquare_u_is_b.sv
// Unary square: unipolar x in, bipolar stream out with P(out=1) = (1 + x^2) / 2; macro USQUARE_OUTCNT_EN adds ones_cnt.
// Latency: 1 cycle from in to out; out_vld rises DEP cycles after reset release.
// Backpressure: none, one bit in and one bit out every cycle.
module usquare_u_is_b
   import unary_pkg::*;
#(
   parameter int unsigned DEP    = 4,
   parameter int unsigned DEPLOG = 2
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DEPLOG-1:0] randNum,
   input  logic              in,
   output logic              out,
   output logic              out_vld
`ifdef USQUARE_OUTCNT_EN
   ,
   output logic [15:0]       ones_cnt
`endif
);

   localparam int unsigned CW = DEPLOG + 1;

   // Seed alternates 0,1,0,1.. so early reads look like a p=0.5 stream
   localparam logic [DEP-1:0] SEED = DEP'({DEP{2'b10}});

   int unsigned     idx;
   logic [DEP-1:0]  hit;
   logic [DEP-1:0]  shuf_q, shuf_d;
   logic            old;
   logic            sq;
   logic [CW-1:0]   warm_cnt_q, warm_cnt_d;
   logic            out_vld_q, out_vld_d;
   logic            out_bi;

   assign idx = clamp_idx(32'(randNum), DEP);

   // One-hot select of the shuffle entry addressed this cycle
   for (genvar g = 0; g < DEP; g++) begin : g_hit
      assign hit[g] = (idx == g);
   end

   // Read the old entry and overwrite it with the current input in the same cycle
   always_comb begin
      old    = |(shuf_q & hit);
      shuf_d = (shuf_q & ~hit) | ({DEP{in}} & hit);
      sq     = in & old;
   end

   // Shuffle buffer holding decorrelated past input bits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shuf_q <= SEED;
      end else begin
         shuf_q <= shuf_d;
      end
   end

   // Warm-up counter saturating at DEP; valid latches once the buffer has seen DEP writes
   always_comb begin
      warm_cnt_d = warm_cnt_q;
      if (warm_cnt_q != CW'(DEP)) begin
         warm_cnt_d = warm_cnt_q + CW'(1);
      end
      out_vld_d = (warm_cnt_q == CW'(DEP - 1)) | out_vld_q;
   end

   // Warm-up state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         warm_cnt_q <= '0;
         out_vld_q  <= 1'b0;
      end else begin
         warm_cnt_q <= warm_cnt_d;
         out_vld_q  <= out_vld_d;
      end
   end

   usquare_u_is_b_uni2bi u_uni2bi (
      .clk   (clk),
      .rst_n (rst_n),
      .in    (sq),
      .out   (out_bi)
   );

   assign out     = out_bi;
   assign out_vld = out_vld_q;

`ifdef USQUARE_OUTCNT_EN
   logic [15:0] ones_cnt_q, ones_cnt_d;

   // Count valid output ones, holding at all-ones instead of wrapping
   always_comb begin
      ones_cnt_d = ones_cnt_q;
      if (out_bi && out_vld_q && (ones_cnt_q != 16'hFFFF)) begin
         ones_cnt_d = ones_cnt_q + 16'd1;
      end
   end

   // Profiling counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ones_cnt_q <= 16'd0;
      end else begin
         ones_cnt_q <= ones_cnt_d;
      end
   end

   assign ones_cnt = ones_cnt_q;
`else
   // No profiling counter in this build; out and out_vld are unaffected either way.
`endif

endmodule
